// File: rtl/dup_rx_pkg.sv
// Shared definitions for the DUP11 receiver: register bit positions,
// receiver state encoding and the maintenance-select loopback code.
package dup_rx_pkg;

  // RXCSR bit positions
  localparam int RXCSR_DSCA   = 15;
  localparam int RXCSR_RING   = 14;
  localparam int RXCSR_CTS    = 13;
  localparam int RXCSR_CD     = 12;
  localparam int RXCSR_RXACT  = 11;
  localparam int RXCSR_DSR    = 9;
  localparam int RXCSR_STRSYN = 8;
  localparam int RXCSR_RXDONE = 7;
  localparam int RXCSR_RXIE   = 6;
  localparam int RXCSR_DSCIE  = 5;
  localparam int RXCSR_RCVEN  = 4;

  // RXDBUF bit positions
  localparam int RXDBUF_RXERR  = 15;
  localparam int RXDBUF_RXOVRN = 14;

  // Maintenance select value that routes the transmitter back into the receiver
  localparam logic [1:0] MSEL_LOOPBACK = 2'b01;

  // Receiver state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_SYNC = 2'd2
  } rx_state_t;

  // Serial data arrives LSB first: new bit enters at the top and moves down
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {bit_in, cur[7:1]};
  endfunction

endpackage

// File: rtl/dup_sync_edge.sv
// Multi-flop synchronizer for a bundle of asynchronous lines, with per-bit
// rising-edge and change detection on the synchronized values.
module dup_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_change
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;
  logic [WIDTH-1:0]                  r_prev;

  // Synchronizer chain; all lines of the bundle move through it together
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
    end
  end

  // Previous synchronized value, used for edge/change detection
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= r_stage[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign o_rise[gi]   = r_stage[SYNC_STAGES-1][gi] & ~r_prev[gi];
      assign o_change[gi] = r_stage[SYNC_STAGES-1][gi] ^ r_prev[gi];
    end
  endgenerate

endmodule

// File: rtl/dup_rx.sv
// DUP11 receiver: samples the (optionally looped-back) serial stream, hunts
// for the sync character, assembles bytes into RXDBUF and maintains RXCSR.
module dup_rx
  import dup_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic        dupINIT,
  input  logic        devLOBYTE,
  input  logic        devHIBYTE,
  input  logic        rxcsrWRITE,
  input  logic        rxcsrREAD,
  input  logic        rxdbufREAD,
  input  logic [35:0] dupDATAI,
  input  logic [7:0]  dupSYNC,
  input  logic [1:0]  dupMSEL,
  input  logic        dupTXC,
  input  logic        dupTXD,
  input  logic        dupRXC,
  input  logic        dupRXD,
  input  logic        dupCTS,
  input  logic        dupCD,
  input  logic        dupRING,
  input  logic        dupDSR,
  output logic [15:0] regRXCSR,
  output logic [15:0] regRXDBUF,
  output logic        rxINTR
);

  // Receiver state
  rx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_rxact;

  // RXCSR writable fields and status
  logic       r_rcven;
  logic       r_rxie;
  logic       r_dscie;
  logic       r_strsyn;
  logic       r_dsca;

  // RXDBUF contents
  logic       r_rxdone;
  logic       r_rxovrn;
  logic       r_rxerr;
  logic [7:0] r_data;

  logic       r_intr;

  // Combinational helpers
  logic       w_clr;
  logic       w_clk_src;
  logic       w_dat_src;
  logic [1:0] w_bit_sync;
  logic [1:0] w_bit_rise;
  logic [1:0] w_bit_chg;
  logic [3:0] w_modem;
  logic [3:0] w_modem_rise;
  logic [3:0] w_modem_chg;
  logic       w_bit_en;
  logic       w_bit;
  logic [7:0] w_shift_next;
  logic       w_lo_wr;
  logic       w_hi_wr;
  logic       w_rcven_off;
  logic       w_rx_stop;
  logic       w_byte_done;
  logic       w_accept;
  logic       w_unused;

  assign w_clr = devRESET | dupINIT;

  // Loopback routes the transmitter clock/data into the receiver path
  assign w_clk_src = (dupMSEL == MSEL_LOOPBACK) ? dupTXC : dupRXC;
  assign w_dat_src = (dupMSEL == MSEL_LOOPBACK) ? dupTXD : dupRXD;

  // Bit clock and data synchronized together so data is aligned with its edge
  dup_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (2)
  ) u_bit_sync (
    .clk      (clk),
    .i_rst_n  (rst),
    .i_d      ({w_clk_src, w_dat_src}),
    .o_sync   (w_bit_sync),
    .o_rise   (w_bit_rise),
    .o_change (w_bit_chg)
  );

  // Modem status lines: {RING, CTS, CD, DSR}
  dup_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (4)
  ) u_modem_sync (
    .clk      (clk),
    .i_rst_n  (rst),
    .i_d      ({dupRING, dupCTS, dupCD, dupDSR}),
    .o_sync   (w_modem),
    .o_rise   (w_modem_rise),
    .o_change (w_modem_chg)
  );

  assign w_bit_en     = w_bit_rise[1];
  assign w_bit        = w_bit_sync[0];
  assign w_shift_next = shift_in(r_shift, w_bit);

  assign w_lo_wr     = rxcsrWRITE & devLOBYTE;
  assign w_hi_wr     = rxcsrWRITE & devHIBYTE;
  assign w_rcven_off = w_lo_wr & ~dupDATAI[RXCSR_RCVEN];
  assign w_rx_stop   = w_rcven_off | ~r_rcven;

  // A byte completes on the eighth bit after sync; a concurrent RCVEN clear drops it
  assign w_byte_done = (r_state == ST_SYNC) & w_bit_en & (r_bitcnt == 3'd7) & ~w_rx_stop;
  assign w_accept    = w_byte_done & ~(r_strsyn & (w_shift_next == dupSYNC));

  // Bits of the device bus and synchronizer outputs with no function here
  assign w_unused = ^{dupDATAI[35:16], dupDATAI[15:9], dupDATAI[7], dupDATAI[3:0],
                      w_bit_rise[0], w_bit_chg, w_modem_rise};

  // Receiver FSM: IDLE -> HUNT for sync -> SYNC assembling bytes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_rxact  <= 1'b0;
    end else if (w_clr) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_rxact  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_shift  <= '0;
          r_bitcnt <= '0;
          r_rxact  <= 1'b0;
          if (!w_rx_stop) begin
            r_state <= ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (w_rx_stop) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_rxact <= 1'b0;
          end else if (w_bit_en) begin
            r_shift <= w_shift_next;
            if (w_shift_next == dupSYNC) begin
              r_state  <= ST_SYNC;
              r_rxact  <= 1'b1;
              r_bitcnt <= '0;
            end
          end
        end
        ST_SYNC: begin
          if (w_rx_stop) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_rxact  <= 1'b0;
          end else if (w_bit_en) begin
            r_shift  <= w_shift_next;
            r_bitcnt <= r_bitcnt + 3'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_shift  <= '0;
          r_bitcnt <= '0;
          r_rxact  <= 1'b0;
        end
      endcase
    end
  end

  // RXDBUF data and done/overrun/error flags; a completing byte beats a read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data   <= '0;
      r_rxdone <= 1'b0;
      r_rxovrn <= 1'b0;
      r_rxerr  <= 1'b0;
    end else if (w_clr) begin
      r_data   <= '0;
      r_rxdone <= 1'b0;
      r_rxovrn <= 1'b0;
      r_rxerr  <= 1'b0;
    end else if (w_accept) begin
      r_data   <= w_shift_next;
      r_rxdone <= 1'b1;
      if (r_rxdone && !rxdbufREAD) begin
        r_rxovrn <= 1'b1;
        r_rxerr  <= 1'b1;
      end else if (rxdbufREAD) begin
        r_rxovrn <= 1'b0;
        r_rxerr  <= 1'b0;
      end
    end else if (rxdbufREAD) begin
      r_rxdone <= 1'b0;
      r_rxovrn <= 1'b0;
      r_rxerr  <= 1'b0;
    end
  end

  // Writable RXCSR fields, split by byte lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcven  <= 1'b0;
      r_rxie   <= 1'b0;
      r_dscie  <= 1'b0;
      r_strsyn <= 1'b0;
    end else if (w_clr) begin
      r_rcven  <= 1'b0;
      r_rxie   <= 1'b0;
      r_dscie  <= 1'b0;
      r_strsyn <= 1'b0;
    end else begin
      if (w_lo_wr) begin
        r_rxie  <= dupDATAI[RXCSR_RXIE];
        r_dscie <= dupDATAI[RXCSR_DSCIE];
        r_rcven <= dupDATAI[RXCSR_RCVEN];
      end
      if (w_hi_wr) begin
        r_strsyn <= dupDATAI[RXCSR_STRSYN];
      end
    end
  end

  // Dataset change flag; a new change beats the clearing read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dsca <= 1'b0;
    end else if (w_clr) begin
      r_dsca <= 1'b0;
    end else if (|w_modem_chg) begin
      r_dsca <= 1'b1;
    end else if (rxcsrREAD) begin
      r_dsca <= 1'b0;
    end
  end

  // Registered interrupt request, one clk behind the flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_intr <= 1'b0;
    end else if (w_clr) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= (r_rxie & r_rxdone) | (r_dscie & r_dsca);
    end
  end

  // Register read views
  always_comb begin
    regRXCSR                = '0;
    regRXCSR[RXCSR_DSCA]    = r_dsca;
    regRXCSR[RXCSR_RING]    = w_modem[3];
    regRXCSR[RXCSR_CTS]     = w_modem[2];
    regRXCSR[RXCSR_CD]      = w_modem[1];
    regRXCSR[RXCSR_RXACT]   = r_rxact;
    regRXCSR[RXCSR_DSR]     = w_modem[0];
    regRXCSR[RXCSR_STRSYN]  = r_strsyn;
    regRXCSR[RXCSR_RXDONE]  = r_rxdone;
    regRXCSR[RXCSR_RXIE]    = r_rxie;
    regRXCSR[RXCSR_DSCIE]   = r_dscie;
    regRXCSR[RXCSR_RCVEN]   = r_rcven;

    regRXDBUF                = '0;
    regRXDBUF[RXDBUF_RXERR]  = r_rxerr;
    regRXDBUF[RXDBUF_RXOVRN] = r_rxovrn;
    regRXDBUF[7:0]           = r_data;
  end

  assign rxINTR = r_intr;

endmodule

// File: doc/dup_rx.md
Name: dup_rx

Overview:
- DUP11 receiver section, the counterpart of the DUP11 transmitter CSR.
- Samples the modem receive clock and data, hunts for the sync character, and assembles LSB-first bytes into RXDBUF.
- Maintains the RXCSR (status, enables, modem-change) and RXDBUF (data, error/overrun) registers.
- Sits beside the TXCSR and PARCSR logic inside the DUP11 device; registers are read and written through the UBA device bus.

Parameters:
- SYNC_STAGES, 2, number of metastability flops on the dupRXC, dupRXD and modem inputs (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- devRESET  input  1  device reset from UBA; synchronous clear, same effect as rst
- dupINIT  input  1  INIT pulse from TXCSR; synchronous clear, same effect as rst
- devLOBYTE  input  1  low-byte write strobe qualifier
- devHIBYTE  input  1  high-byte write strobe qualifier
- rxcsrWRITE  input  1  RXCSR write strobe
- rxcsrREAD  input  1  RXCSR read strobe; clears DSCA
- rxdbufREAD  input  1  RXDBUF read strobe; clears RXDONE, RXOVRN, RXERR
- dupDATAI  input  36  device write data; bits [15:0] used
- dupSYNC  input  8  sync character from PARCSR[7:0]
- dupMSEL  input  2  maintenance select from TXCSR; 2'b01 = internal loopback
- dupTXC, dupTXD  input  1 each  transmitter clock and data, used in loopback
- dupRXC, dupRXD  input  1 each  modem receive clock and data (asynchronous)
- dupCTS, dupCD, dupRING, dupDSR  input  1 each  modem status (asynchronous)
- regRXCSR  output  16  RXCSR read value
- regRXDBUF  output  16  RXDBUF read value
- rxINTR  output  1  receive interrupt request (level)

Behaviour:
- Reset and clear: rst, devRESET and dupINIT clear every register. After a clear, regRXCSR and regRXDBUF show only the live modem bits, and rxINTR = 0.
- Input source: in loopback (dupMSEL = 01) the bit clock is dupTXC and the data is dupTXD; otherwise dupRXC and dupRXD. Both pass through SYNC_STAGES flops.
- Bit sampling: one bit is taken on each detected rising edge of the synchronized bit clock (bitEN, one clk wide).
- Receiver state machine:
  - States: IDLE, HUNT, SYNC.
  - IDLE -> HUNT when RCVEN = 1.
  - HUNT: on bitEN, shift the 8-bit register right with the new bit into bit 7. When the register equals dupSYNC, go to SYNC, set RXACT, and set bit count = 0.
  - SYNC: on bitEN, shift and increment a 3-bit bit count. When the count wraps from 7 to 0, a byte is complete.
  - On byte complete: if STRSYN = 1 and the byte equals dupSYNC, discard it. Otherwise load RXDBUF[7:0] and set RXDONE on the next clk.
  - On byte complete with RXDONE already 1: set RXOVRN and RXERR, and overwrite the data byte.
  - RCVEN written 0, in any state: go to IDLE the next clk, clear RXACT, drop any partial byte, and do not set RXDONE.
- RXCSR read layout: 15 DSCA, 14 RING, 13 CTS, 12 CD, 11 RXACT, 10 0, 9 DSR, 8 STRSYN, 7 RXDONE, 6 RXIE, 5 DSCIE, 4 RCVEN, 3:0 0.
- RXCSR writes:
  - Low byte writes RXIE, DSCIE, RCVEN.
  - High byte writes STRSYN.
  - All other bits are read-only.
- Modem change (DSCA): a change on any synchronized RING, CTS, CD or DSR sets DSCA.
- DSCA clear: rxcsrREAD clears DSCA. A change in the same cycle as the read wins, and DSCA stays 1.
- RXDBUF read layout: 15 RXERR, 14 RXOVRN, 13:8 0, 7:0 data.
- RXDBUF read effect: rxdbufREAD clears RXDONE, RXOVRN and RXERR. A byte completing in the same cycle wins, and RXDONE stays 1 with the new data.
- Interrupt: rxINTR = (RXIE & RXDONE) | (DSCIE & DSCA), registered, one clk after the flag is set.
- Latency: RXDONE is visible 1 clk after the bitEN that completes the byte, and SYNC_STAGES+1 clk after the dupRXC edge.

Decomposition:
- Shared package dup_rx_pkg holds:
  - RXCSR bit-position constants.
  - RXDBUF bit-position constants.
  - The state encoding (IDLE = 0, HUNT = 1, SYNC = 2).
  - The MSEL loopback code.
- One natural sub-module: dup_sync_edge, a SYNC_STAGES synchronizer plus rising-edge detect. It is instantiated once for the bit clock, with data synchronized alongside, and reused for the modem lines.

Test Plan:
- RCVEN = 1, STRSYN = 1, dupSYNC = 0x96; send 0x96, 0x96, 0x41 LSB-first -> RXACT = 1 after the first 0x96, exactly one RXDONE, regRXDBUF = 0x0041.
- STRSYN = 0, same stream -> RXDONE for 0x96 (second char) and then 0x41; the first 0x96 is consumed as sync.
- Send 0x41, 0x42 without reading -> RXDBUF = 0xC042 (RXERR, RXOVRN set); then rxdbufREAD -> RXDONE = 0, RXDBUF[15:14] = 0.
- RXIE = 1, byte received -> rxINTR = 1; rxdbufREAD -> rxINTR = 0 one clk later. DSCIE = 1, toggle dupCD -> RXCSR[15] = 1 and rxINTR = 1; rxcsrREAD clears both.
- Clear RCVEN after 4 bits of a byte -> state IDLE, RXACT = 0, no RXDONE. dupINIT mid-byte -> all fields return to reset values.
- dupMSEL = 01, drive dupTXC/dupTXD with 0x96 then 0x55, dupRXC held low -> RXDBUF[7:0] = 0x55.
